// File: rtl/rl_ram_fifo_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : rl_ram_fifo_ctrl_if
// Description : Push/pop handshake bundle for the RAM-backed FIFO controller.
//               Signal suffixes are named from the FIFO's point of view.
// Revision    : 1.0 - initial release
// ============================================================================
interface rl_ram_fifo_ctrl_if #(
    parameter int DBITS = 32
);
    logic             push_valid_i;
    logic [DBITS-1:0] push_data_i;
    logic             push_ready_o;
    logic             pop_valid_o;
    logic [DBITS-1:0] pop_data_o;
    logic             pop_ready_i;

    modport master (
        output push_valid_i,
        output push_data_i,
        input  push_ready_o,
        input  pop_valid_o,
        input  pop_data_o,
        output pop_ready_i
    );

    modport slave (
        input  push_valid_i,
        input  push_data_i,
        output push_ready_o,
        output pop_valid_o,
        output pop_data_o,
        input  pop_ready_i
    );
endinterface
`default_nettype wire

// File: rtl/rl_ram_fifo_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : rl_ram_fifo_ctrl
// Description : FIFO controller around an external 1R1W registered-read RAM,
//               with a 2-entry output queue to hide the RAM read latency.
// Revision    : 1.0 - initial release
// ============================================================================
module rl_ram_fifo_ctrl #(
    parameter int ABITS = 4,
    parameter int DBITS = 32
) (
    input  wire logic                   clk_i,
    input  wire logic                   rst_i,
    input  wire logic                   flush_i,
    rl_ram_fifo_ctrl_if.slave           fifo_if,
    output logic [ABITS-1:0]            ram_waddr_o,
    output logic [DBITS-1:0]            ram_din_o,
    output logic                        ram_we_o,
    output logic [(DBITS+7)/8-1:0]      ram_be_o,
    output logic [ABITS-1:0]            ram_raddr_o,
    input  wire logic [DBITS-1:0]       ram_dout_i,
    output logic [ABITS+1:0]            count_o,
    output logic                        empty_o,
    output logic                        full_o
);

    localparam int unsigned      c_DEPTH_I = 2**ABITS;
    localparam logic [ABITS:0]   c_DEPTH   = c_DEPTH_I[ABITS:0];

    logic [ABITS-1:0] wr_ptr_q,   wr_ptr_d;
    logic [ABITS-1:0] rd_ptr_q,   rd_ptr_d;
    logic [ABITS:0]   ram_cnt_q,  ram_cnt_d;
    logic             inflight_q, inflight_d;
    logic [1:0]       out_cnt_q,  out_cnt_d;
    logic [DBITS-1:0] head_q,     head_d;
    logic [DBITS-1:0] tail_q,     tail_d;

    logic             w_push_ready;
    logic             w_push_fire;
    logic             w_pop_valid;
    logic             w_pop_fire;
    logic [2:0]       w_out_occ;
    logic             w_issue;
    logic [ABITS+1:0] w_count;

    assign w_push_ready = !rst_i && !flush_i && (ram_cnt_q != c_DEPTH);
    assign w_push_fire  = fifo_if.push_valid_i && w_push_ready;
    assign w_pop_valid  = !rst_i && !flush_i && (out_cnt_q != 2'd0);
    assign w_pop_fire   = w_pop_valid && fifo_if.pop_ready_i;

    // Output-queue slots already claimed once this cycle's pop leaves;
    // a read is issued only if its returning word is guaranteed a slot.
    assign w_out_occ = {1'b0, out_cnt_q} + {2'b00, inflight_q} - {2'b00, w_pop_fire};
    assign w_issue   = !rst_i && !flush_i && (ram_cnt_q != '0) && (w_out_occ < 3'd2);

    assign w_count = {1'b0, ram_cnt_q}
                   + {{(ABITS+1){1'b0}}, inflight_q}
                   + {{ABITS{1'b0}}, out_cnt_q};

    assign fifo_if.push_ready_o = w_push_ready;
    assign fifo_if.pop_valid_o  = w_pop_valid;
    assign fifo_if.pop_data_o   = head_q;

    assign ram_we_o    = w_push_fire;
    assign ram_waddr_o = wr_ptr_q;
    assign ram_din_o   = fifo_if.push_data_i;
    assign ram_be_o    = '1;
    assign ram_raddr_o = rd_ptr_q;

    assign count_o = rst_i ? '0 : w_count;
    assign empty_o = (count_o == '0);
    assign full_o  = !rst_i && !flush_i && (ram_cnt_q == c_DEPTH);

    always_comb begin
        wr_ptr_d   = w_push_fire ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d   = w_issue     ? rd_ptr_q + 1'b1 : rd_ptr_q;
        inflight_d = w_issue;
        ram_cnt_d  = ram_cnt_q;
        out_cnt_d  = out_cnt_q;
        head_d     = head_q;
        tail_d     = tail_q;

        case ({w_push_fire, w_issue})
            2'b10:   ram_cnt_d = ram_cnt_q + 1'b1;
            2'b01:   ram_cnt_d = ram_cnt_q - 1'b1;
            default: ram_cnt_d = ram_cnt_q;
        endcase

        if (inflight_q && w_pop_fire) begin
            if (out_cnt_q == 2'd2) begin
                head_d = tail_q;
                tail_d = ram_dout_i;
            end else begin
                head_d = ram_dout_i;
            end
        end else if (inflight_q) begin
            if (out_cnt_q == 2'd0) begin
                head_d = ram_dout_i;
            end else begin
                tail_d = ram_dout_i;
            end
            out_cnt_d = out_cnt_q + 2'd1;
        end else if (w_pop_fire) begin
            head_d    = tail_q;
            out_cnt_d = out_cnt_q - 2'd1;
        end

        // The word returning from the RAM this cycle is simply not appended.
        if (flush_i) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            ram_cnt_d  = '0;
            inflight_d = 1'b0;
            out_cnt_d  = 2'd0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            ram_cnt_q  <= '0;
            inflight_q <= 1'b0;
            out_cnt_q  <= 2'd0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            ram_cnt_q  <= ram_cnt_d;
            inflight_q <= inflight_d;
            out_cnt_q  <= out_cnt_d;
        end
    end

    // Payload registers are qualified by out_cnt_q, so they need no reset.
    always_ff @(posedge clk_i) begin
        head_q <= head_d;
        tail_q <= tail_d;
    end

endmodule
`default_nettype wire
